// File: rtl/axi_slave_write_engine.sv
// axi_slave_write_engine: AXI3/AXI4 slave write path forwarding W beats to the mesh, with a queued B channel.
// Optional AXI_WLAST_CHECK_EN: wlast ends the burst, and wlast/length disagreement returns SLVERR.
module axi_slave_write_engine #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int ID_W     = 12,
   parameter int LEN_W    = 8,
   parameter int BQ_DEPTH = 4
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [ID_W-1:0]     s_axi_awid,
   input  logic [ADDR_W-1:0]   s_axi_awaddr,
   input  logic [LEN_W-1:0]    s_axi_awlen,
   input  logic [2:0]          s_axi_awsize,
   input  logic [1:0]          s_axi_awburst,
   input  logic                s_axi_awvalid,
   output logic                s_axi_awready,
   input  logic [DATA_W-1:0]   s_axi_wdata,
   input  logic [DATA_W/8-1:0] s_axi_wstrb,
   input  logic                s_axi_wlast,
   input  logic                s_axi_wvalid,
   output logic                s_axi_wready,
   output logic [ID_W-1:0]     s_axi_bid,
   output logic [1:0]          s_axi_bresp,
   output logic                s_axi_bvalid,
   input  logic                s_axi_bready,
   output logic                wr_access,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [DATA_W-1:0]   wr_data,
   output logic [DATA_W/8-1:0] wr_strb,
   input  logic                wr_wait
);
   localparam int         QW     = $clog2(BQ_DEPTH);
   localparam logic [QW:0] QMAX  = (QW+1)'(BQ_DEPTH);
   localparam logic [2:0] SZ_MAX = 3'($clog2(DATA_W/8));
   localparam logic [1:0] FIXED  = 2'd0;
   localparam logic [1:0] INCR   = 2'd1;
   localparam logic [1:0] WRAP   = 2'd2;

   typedef enum logic {IDLE, DATA} state_t;
   state_t r_state, w_state_nxt;

   logic                r_awready;
   logic [ID_W-1:0]     r_id;
   logic [ADDR_W-1:0]   r_addr;
   logic [LEN_W-1:0]    r_len, r_cnt;
   logic [2:0]          r_size;
   logic [1:0]          r_burst;
   logic                r_err;
   logic                r_wr_access;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [DATA_W-1:0]   r_wr_data;
   logic [DATA_W/8-1:0] r_wr_strb;
   logic [ID_W-1:0]     r_bq_id   [BQ_DEPTH];
   logic [1:0]          r_bq_resp [BQ_DEPTH];
   logic [QW-1:0]       r_wp, r_rp;
   logic [QW:0]         r_qcount, w_qcount_nxt;
   logic                w_aw_hs, w_w_hs, w_wready, w_final, w_end, w_berr;
   logic                w_push, w_pop, w_bvalid, w_wrap_ok, w_aw_err;
   logic [1:0]          w_burst_eff;
   logic [ADDR_W-1:0]   w_bytes, w_mask, w_addr_nxt;

   always_comb begin
      w_wready     = (r_state == DATA) && !wr_wait;
      w_aw_hs      = r_awready && s_axi_awvalid;
      w_w_hs       = w_wready && s_axi_wvalid;
      w_final      = r_cnt == r_len;
`ifdef AXI_WLAST_CHECK_EN
      w_end        = w_final || s_axi_wlast;
      w_berr       = r_err || (s_axi_wlast != w_final);
`else
      w_end        = w_final;
      w_berr       = r_err;
`endif
      w_push       = w_w_hs && w_end;
      w_bvalid     = r_qcount != '0;
      w_pop        = w_bvalid && s_axi_bready;
      w_qcount_nxt = r_qcount + (QW+1)'(w_push) - (QW+1)'(w_pop);
      w_state_nxt  = (r_state == IDLE) ? (w_aw_hs ? DATA : IDLE) : (w_push ? IDLE : DATA);
      w_wrap_ok    = s_axi_awlen == LEN_W'(1) || s_axi_awlen == LEN_W'(3) ||
                     s_axi_awlen == LEN_W'(7) || s_axi_awlen == LEN_W'(15);
      w_aw_err     = (s_axi_awsize > SZ_MAX) || (s_axi_awburst == 2'd3) ||
                     (s_axi_awburst == WRAP && !w_wrap_ok);
      // Reserved bursts and illegal WRAP lengths degrade to INCR addressing.
      w_burst_eff  = (s_axi_awburst == FIXED) ? FIXED : (s_axi_awburst == WRAP && w_wrap_ok) ? WRAP : INCR;
      w_bytes      = ADDR_W'(1) << r_size;
      w_mask       = ((ADDR_W'(r_len) + ADDR_W'(1)) << r_size) - ADDR_W'(1);
      w_addr_nxt   = (r_burst == FIXED) ? r_addr :
                     (r_burst == WRAP)  ? ((r_addr & ~w_mask) | ((r_addr + w_bytes) & w_mask)) :
                                          r_addr + w_bytes;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_awready   <= 1'b0;
         r_wr_access <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_wr_strb   <= '0;
         r_cnt       <= '0;
         r_qcount    <= '0;
         r_wp        <= '0;
         r_rp        <= '0;
      end else begin
         r_awready   <= (w_state_nxt == IDLE) && (w_qcount_nxt < QMAX);
         r_wr_access <= w_w_hs;
         r_qcount    <= w_qcount_nxt;
         if (w_aw_hs) begin
            r_id    <= s_axi_awid;
            r_addr  <= s_axi_awaddr;
            r_len   <= s_axi_awlen;
            r_size  <= s_axi_awsize;
            r_burst <= w_burst_eff;
            r_err   <= w_aw_err;
            r_cnt   <= '0;
         end
         if (w_w_hs) begin
            r_wr_addr <= r_addr;
            r_wr_data <= s_axi_wdata;
            r_wr_strb <= s_axi_wstrb;
            r_addr    <= w_addr_nxt;
            r_cnt     <= r_cnt + 1'b1;
         end
         if (w_push) begin
            r_bq_id[r_wp]   <= r_id;
            r_bq_resp[r_wp] <= w_berr ? 2'b10 : 2'b00;
            r_wp            <= r_wp + 1'b1;
         end
         if (w_pop) r_rp <= r_rp + 1'b1;
      end
   end

   // Queue storage is not reset, so the head is masked while the queue is empty.
   assign s_axi_awready = r_awready;
   assign s_axi_wready  = w_wready;
   assign s_axi_bvalid  = w_bvalid;
   assign s_axi_bid     = w_bvalid ? r_bq_id[r_rp] : '0;
   assign s_axi_bresp   = w_bvalid ? r_bq_resp[r_rp] : 2'b00;
   assign wr_access     = r_wr_access;
   assign wr_addr       = r_wr_addr;
   assign wr_data       = r_wr_data;
   assign wr_strb       = r_wr_strb;
endmodule

// File: tb/tb_axi_slave_write_engine.sv
// tb_axi_slave_write_engine: scoreboard bench for the AXI slave write engine.
// Expected beats and responses are queued as stimulus is issued and compared as the DUT emits them.
module tb_axi_slave_write_engine;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] s_axi_awid = '0;
   logic [31:0] s_axi_awaddr = '0;
   logic [7:0]  s_axi_awlen = '0;
   logic [2:0]  s_axi_awsize = '0;
   logic [1:0]  s_axi_awburst = '0;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_wlast = 1'b0;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [11:0] s_axi_bid;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b1;
   logic        wr_access;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_wait = 1'b0;

   always #5 clk = ~clk;

   axi_slave_write_engine dut (
      .clk(clk), .rst(rst),
      .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready),
      .wr_access(wr_access), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
      .wr_wait(wr_wait)
   );

   typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] s;} wexp_t;
   typedef struct packed {logic [11:0] id; logic [1:0] r;} bexp_t;
   wexp_t exp_w[$];
   bexp_t exp_b[$];
   wexp_t we;
   bexp_t be;
   int checks = 0, failures = 0;
   int run = 0, max_run = 0, acc_cnt = 0;

   always @(negedge clk) begin
      if (wr_access) begin
         acc_cnt++;
         run++;
         if (run > max_run) max_run = run;
         checks++;
         if (exp_w.size() == 0) begin
            failures++;
            $display("FAIL wr_unexpected got addr=%h data=%h", wr_addr, wr_data);
         end else begin
            we = exp_w.pop_front();
            if ({wr_addr, wr_data, wr_strb} !== we) begin
               failures++;
               $display("FAIL wr_beat got addr=%h data=%h strb=%h exp addr=%h data=%h strb=%h",
                        wr_addr, wr_data, wr_strb, we.a, we.d, we.s);
            end
         end
      end else run = 0;
      if (s_axi_bvalid && s_axi_bready) begin
         checks++;
         if (exp_b.size() == 0) begin
            failures++;
            $display("FAIL b_unexpected got bid=%h bresp=%0d", s_axi_bid, s_axi_bresp);
         end else begin
            be = exp_b.pop_front();
            if ({s_axi_bid, s_axi_bresp} !== be) begin
               failures++;
               $display("FAIL b_resp got bid=%h bresp=%0d exp bid=%h bresp=%0d",
                        s_axi_bid, s_axi_bresp, be.id, be.r);
            end
         end
      end
   end

   task automatic push_w(input logic [31:0] a, input logic [31:0] d);
      exp_w.push_back({a, d, d[3:0]});
   endtask

   task automatic push_b(input logic [11:0] id, input logic [1:0] r);
      exp_b.push_back({id, r});
   endtask

   task automatic do_aw(input logic [11:0] id, input logic [31:0] a, input logic [7:0] len,
                        input logic [2:0] sz, input logic [1:0] bu);
      int n = 0;
      s_axi_awid = id; s_axi_awaddr = a; s_axi_awlen = len; s_axi_awsize = sz;
      s_axi_awburst = bu; s_axi_awvalid = 1'b1;
      @(negedge clk);
      while (!s_axi_awready && n < 100) begin n++; @(negedge clk); end
      if (!s_axi_awready) begin
         checks++; failures++;
         $display("FAIL aw_timeout got awready=0 exp 1 id=%h", id);
      end
      @(posedge clk); #1 s_axi_awvalid = 1'b0;
   endtask

   task automatic do_w(input logic [31:0] d, input logic last);
      int n = 0;
      s_axi_wdata = d; s_axi_wstrb = d[3:0]; s_axi_wlast = last; s_axi_wvalid = 1'b1;
      @(negedge clk);
      while (!s_axi_wready && n < 100) begin n++; @(negedge clk); end
      if (!s_axi_wready) begin
         checks++; failures++;
         $display("FAIL w_timeout got wready=0 exp 1 data=%h", d);
      end
      @(posedge clk); #1 s_axi_wvalid = 1'b0;
   endtask

   task automatic send_burst(input logic [11:0] id, input logic [31:0] a, input logic [7:0] len,
                             input logic [2:0] sz, input logic [1:0] bu, input logic [31:0] dbase);
      do_aw(id, a, len, sz, bu);
      for (int i = 0; i <= int'(len); i++) do_w(dbase + 32'(i), i == int'(len));
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_w.size() != 0 || exp_b.size() != 0) && n < 100) begin n++; @(negedge clk); end
      checks++;
      if (exp_w.size() != 0 || exp_b.size() != 0) begin
         failures++;
         $display("FAIL drain got pending beats=%0d resps=%0d exp 0/0", exp_w.size(), exp_b.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b000) begin
         failures++;
         $display("FAIL reset_ready got aw/w/b=%b exp 000", {s_axi_awready, s_axi_wready, s_axi_bvalid});
      end
      checks++;
      if ({s_axi_bid, s_axi_bresp} !== 14'h0) begin
         failures++;
         $display("FAIL reset_b got bid=%h bresp=%0d exp 0", s_axi_bid, s_axi_bresp);
      end
      checks++;
      if ({wr_access, wr_addr, wr_data, wr_strb} !== 69'h0) begin
         failures++;
         $display("FAIL reset_wr got access=%b addr=%h data=%h strb=%h exp 0", wr_access, wr_addr, wr_data, wr_strb);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (s_axi_awready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_awready got %b exp 1", s_axi_awready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_incr();
      for (int i = 0; i < 4; i++) push_w(32'h1000 + 32'(4*i), 32'hA000_0000 + 32'(i));
      push_b(12'h123, 2'd0);
      max_run = 0;
      send_burst(12'h123, 32'h1000, 8'd3, 3'd2, 2'd1, 32'hA000_0000);
      drain();
      checks++;
      if (max_run !== 4) begin
         failures++;
         $display("FAIL incr_back_to_back got run=%0d exp 4", max_run);
      end
   endtask

   task automatic test_wrap();
      push_w(32'h1008, 32'hB000_0000);
      push_w(32'h100C, 32'hB000_0001);
      push_w(32'h1000, 32'hB000_0002);
      push_w(32'h1004, 32'hB000_0003);
      push_b(12'h0A5, 2'd0);
      send_burst(12'h0A5, 32'h1008, 8'd3, 3'd2, 2'd2, 32'hB000_0000);
      drain();
   endtask

   task automatic test_fixed_wait();
      int a0 = acc_cnt;
      push_w(32'h20, 32'hC000_0001);
      push_w(32'h20, 32'hC000_0002);
      push_b(12'h777, 2'd0);
      do_aw(12'h777, 32'h20, 8'd1, 3'd2, 2'd0);
      do_w(32'hC000_0001, 1'b0);
      wr_wait = 1'b1;
      s_axi_wdata = 32'hC000_0002; s_axi_wstrb = 4'h2; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (s_axi_wready !== 1'b0) begin
            failures++;
            $display("FAIL fixed_wait_wready cycle=%0d got %b exp 0", i, s_axi_wready);
         end
         @(posedge clk);
      end
      #1 wr_wait = 1'b0;
      @(negedge clk);
      checks++;
      if (s_axi_wready !== 1'b1) begin
         failures++;
         $display("FAIL fixed_release_wready got %b exp 1", s_axi_wready);
      end
      @(posedge clk); #1 s_axi_wvalid = 1'b0;
      drain();
      checks++;
      if (acc_cnt - a0 !== 2) begin
         failures++;
         $display("FAIL fixed_pulses got %0d exp 2", acc_cnt - a0);
      end
   endtask

   task automatic test_bq_full();
      s_axi_bready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         push_w(32'h200 + 32'(16*i), 32'hD000_0000 + 32'(i));
         push_b(12'(i), 2'd0);
         send_burst(12'(i), 32'h200 + 32'(16*i), 8'd0, 3'd2, 2'd1, 32'hD000_0000 + 32'(i));
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({s_axi_awready, s_axi_bvalid} !== 2'b01) begin
         failures++;
         $display("FAIL bq_full got awready=%b bvalid=%b exp 0/1", s_axi_awready, s_axi_bvalid);
      end
      @(posedge clk); #1 s_axi_bready = 1'b1;
      drain();
      @(negedge clk);
      checks++;
      if (s_axi_awready !== 1'b1) begin
         failures++;
         $display("FAIL bq_awready_back got %b exp 1", s_axi_awready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_errors();
      push_w(32'h40, 32'hE000_0000);
      push_b(12'h301, 2'd2);
      send_burst(12'h301, 32'h40, 8'd0, 3'd3, 2'd1, 32'hE000_0000);
      push_w(32'h80, 32'hE100_0000);
      push_w(32'h84, 32'hE100_0001);
      push_b(12'h302, 2'd2);
      send_burst(12'h302, 32'h80, 8'd1, 3'd2, 2'd3, 32'hE100_0000);
      push_w(32'h104, 32'hE200_0000);
      push_w(32'h108, 32'hE200_0001);
      push_w(32'h10C, 32'hE200_0002);
      push_b(12'h303, 2'd2);
      send_burst(12'h303, 32'h104, 8'd2, 3'd2, 2'd2, 32'hE200_0000);
      drain();
   endtask

   task automatic test_wlast();
`ifdef AXI_WLAST_CHECK_EN
      push_w(32'h3000, 32'hF000_0000);
      push_w(32'h3004, 32'hF000_0001);
      push_b(12'h401, 2'd2);
      do_aw(12'h401, 32'h3000, 8'd3, 3'd2, 2'd1);
      do_w(32'hF000_0000, 1'b0);
      do_w(32'hF000_0001, 1'b1);
      drain();
      @(negedge clk);
      checks++;
      if ({s_axi_awready, s_axi_wready} !== 2'b10) begin
         failures++;
         $display("FAIL wlast_idle got awready=%b wready=%b exp 1/0", s_axi_awready, s_axi_wready);
      end
      @(posedge clk); #1;
`else
      push_w(32'h3000, 32'hF000_0000);
      push_w(32'h3004, 32'hF000_0001);
      push_b(12'h402, 2'd0);
      do_aw(12'h402, 32'h3000, 8'd1, 3'd2, 2'd1);
      do_w(32'hF000_0000, 1'b1);
      do_w(32'hF000_0001, 1'b0);
      drain();
`endif
   endtask

   task automatic test_reset_mid();
      s_axi_bready = 1'b0;
      push_w(32'h500, 32'h5100_0000);
      push_b(12'h051, 2'd0);
      send_burst(12'h051, 32'h500, 8'd0, 3'd2, 2'd1, 32'h5100_0000);
      push_w(32'h600, 32'h5200_0000);
      push_b(12'h052, 2'd0);
      send_burst(12'h052, 32'h600, 8'd0, 3'd2, 2'd1, 32'h5200_0000);
      push_w(32'h5000, 32'h5300_0000);
      do_aw(12'h053, 32'h5000, 8'd7, 3'd2, 2'd1);
      do_w(32'h5300_0000, 1'b0);
      s_axi_wdata = 32'h5300_0001; s_axi_wstrb = 4'h1; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({s_axi_bvalid, s_axi_awready, wr_access} !== 3'b000) begin
         failures++;
         $display("FAIL rst_mid got bvalid=%b awready=%b wr_access=%b exp 000",
                  s_axi_bvalid, s_axi_awready, wr_access);
      end
      exp_b.delete();
      @(posedge clk); #1 rst = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({s_axi_awready, s_axi_bvalid} !== 2'b10) begin
         failures++;
         $display("FAIL rst_mid_release got awready=%b bvalid=%b exp 1/0", s_axi_awready, s_axi_bvalid);
      end
      @(posedge clk); #1;
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_incr();
      test_wrap();
      test_fixed_wait();
      test_bq_full();
      test_errors();
      test_wlast();
      test_reset_mid();
      test_incr();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axi_slave_write_engine.md
Name: axi_slave_write_engine

Overview:
Parametrised AXI3/AXI4 slave write-channel engine; successor to the single-outstanding esaxi write path.
- Accepts AW bursts and generates per-beat addresses for FIXED/INCR/WRAP.
- Forwards each W beat as an address/data/strobe packet on the mesh write interface (wr_access/wr_wait).
- Returns B responses through a BQ_DEPTH-deep response queue, so new bursts are accepted while earlier responses are still pending.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; power of two, 8..128
ID_W, 12, AXI ID width
LEN_W, 8, burst length width (4 = AXI3, 8 = AXI4)
BQ_DEPTH, 4, B-response queue entries; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axi_awid  in  ID_W  write ID
s_axi_awaddr  in  ADDR_W  start address
s_axi_awlen  in  LEN_W  beats-1
s_axi_awsize  in  3  log2 bytes/beat
s_axi_awburst  in  2  0=FIXED 1=INCR 2=WRAP
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_W  write data
s_axi_wstrb  in  DATA_W/8  byte strobes
s_axi_wlast  in  1  last beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  ID_W  response ID
s_axi_bresp  out  2  0=OKAY 2=SLVERR
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
wr_access  out  1  packet valid, one cycle per beat
wr_addr  out  ADDR_W  beat address
wr_data  out  DATA_W  beat data
wr_strb  out  DATA_W/8  beat strobes
wr_wait  in  1  downstream stall

Behaviour:
- Reset values:
  - awready=0, wready=0, bvalid=0, bid=0, bresp=0
  - wr_access=0, wr_addr=0, wr_data=0, wr_strb=0
  - FSM=IDLE, queue count=0, beat counter=0
- Reset asserted mid-burst aborts the burst and discards all queued responses; nothing is emitted for the aborted burst.
- FSM states: IDLE, DATA.
- IDLE:
  - awready = (qcount < BQ_DEPTH), registered.
  - On AW handshake: latch id, addr, len, size, burst and err flag; clear the beat counter; go to DATA next cycle.
  - awready is 0 in DATA.
- err flag is set at AW handshake if:
  - awsize > log2(DATA_W/8), or
  - awburst==3, or
  - awburst==WRAP with len not in {1,3,7,15}.
  - Erroneous bursts are still fully accepted, and their beats are still forwarded.
  - burst==3 is treated as INCR; an illegal WRAP length is treated as INCR.
- DATA:
  - wready = !wr_wait (combinational).
  - On each W handshake, the next cycle gives: wr_access=1, wr_addr=current beat address, wr_data/wr_strb=captured beat.
  - Latency from W handshake to wr_access is 1 cycle; back-to-back beats give wr_access every cycle.
- Address update after each beat, with bytes = 1<<size:
  - FIXED: address unchanged.
  - INCR: addr += bytes, ADDR_W modulo wrap.
  - WRAP: boundary = (len+1)*bytes; addr = (addr & ~(boundary-1)) | ((addr+bytes) & (boundary-1)).
- Final beat is the one with counter==len. On the final-beat handshake:
  - Push {id, err?SLVERR:OKAY} into the B queue.
  - Go to IDLE.
- The B queue is a FIFO:
  - bvalid = (qcount != 0); bid/bresp come from the head entry.
  - Pop on bvalid && bready.
  - Push and pop in the same cycle leave qcount unchanged.
  - Overflow is impossible because AW is gated on qcount < BQ_DEPTH and only one burst is in flight.
- W beats while in IDLE are not accepted (wready=0).

Optional Feature:
AXI_WLAST_CHECK_EN
- Defined:
  - If wlast=1 on a beat with counter != len: that beat ends the burst, its response is SLVERR, and the FSM returns to IDLE.
  - If wlast=0 on the counter==len beat: the burst still ends with SLVERR.
- Undefined: wlast is ignored; the burst ends purely on the counter, and the response depends only on the err flag.

Test Plan:
- INCR, addr=0x1000, len=3, size=2, wr_wait=0, bready=1 -> wr_addr 0x1000/0x1004/0x1008/0x100C on consecutive cycles; one B: bid=awid, bresp=0.
- WRAP, addr=0x1008, len=3, size=2 -> wr_addr 0x1008, 0x100C, 0x1000, 0x1004.
- FIXED, addr=0x20, len=1; wr_wait high 3 cycles during beat 2 -> wready low those cycles, 2 wr_access pulses total, both wr_addr=0x20.
- bready=0; issue 4 single-beat bursts, IDs 1..4 (BQ_DEPTH=4) -> awready drops after the 4th response is queued; then bready=1 -> bid 1,2,3,4 in order, and awready reasserts.
- awsize=3 with DATA_W=32, len=0 -> beat forwarded, bresp=2. With AXI_WLAST_CHECK_EN: len=3, wlast on beat 1 -> 2 beats forwarded, bresp=2, FSM back in IDLE.
- rst asserted during beat 2 of a len=7 burst with 2 queued responses -> next cycle bvalid=0, awready=0, wr_access=0; one cycle after rst deasserts, awready=1.
